// File: rtl/snowbro2_pkg.sv
// Shared types and constants for the Snow Bros 2 SDRAM responder.
// Holds the responder FSM encoding and bank index names.
package snowbro2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG_CMD,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_WR_CMD,
        ST_HOLD
    } state_e;

    localparam logic [1:0] BANK_CPU = 2'd0;
    localparam logic [1:0] BANK_GFX = 2'd1;

    localparam int BURST_MAX = 2;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/snowbro2_rr_arb4.sv
// Four-way round-robin arbiter; the caller owns the pointer register.
// The requester at ptr has top priority, then ptr+1, ptr+2, ptr+3.
module snowbro2_rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [1:0] cand;

    // Scan lowest priority first so the pointer slot wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        cand      = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/snowbro2_sdram_resp.sv
// Serialises loader writes and four bank requests onto one memory
// command port and returns ack/first-data/ready strobes per bank.
module snowbro2_sdram_resp
    import snowbro2_pkg::*;
#(
    parameter int AW    = 22,
    parameter int BURST = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] PROG_ADDR,
    input  logic [15:0]   PROG_DATA,
    input  logic [1:0]    PROG_MASK,
    input  logic [1:0]    PROG_BA,
    input  logic          PROG_WE,
    output logic          PROG_RDY,
    input  logic [AW-1:0] BA0_ADDR,
    input  logic [AW-1:0] BA1_ADDR,
    input  logic [AW-1:0] BA2_ADDR,
    input  logic [AW-1:0] BA3_ADDR,
    input  logic [3:0]    BA_RD,
    input  logic          BA_WR,
    input  logic [15:0]   BA0_DIN,
    input  logic [1:0]    BA0_DIN_M,
    output logic [3:0]    BA_ACK,
    output logic [3:0]    BA_DST,
    output logic [3:0]    BA_RDY,
    output logic [15:0]   DATA_READ,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [1:0]    mem_ba,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_dm,
    input  logic          mem_gnt,
    input  logic          mem_dvalid,
    input  logic [15:0]   mem_dout
);

    localparam int CW = $clog2(BURST) + 1;

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    bank_q, bank_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cs_q, cs_d;
    logic          we_q, we_d;
    logic [1:0]    ba_q, ba_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic [1:0]    dm_q, dm_d;
    logic          prog_rdy_q, prog_rdy_d;
    logic [3:0]    ack_q, ack_d;
    logic [3:0]    dst_q, dst_d;
    logic [3:0]    rdy_q, rdy_d;
    logic [15:0]   rdata_q, rdata_d;

    logic [3:0]    req;
    logic          gnt_valid;
    logic [1:0]    gnt_idx;
    logic [AW-1:0] ba_addr [4];

    assign req = {BA_RD[3:1], BA_RD[0] | BA_WR};

    assign ba_addr[0] = BA0_ADDR;
    assign ba_addr[1] = BA1_ADDR;
    assign ba_addr[2] = BA2_ADDR;
    assign ba_addr[3] = BA3_ADDR;

    snowbro2_rr_arb4 u_arb (
        .req      (req),
        .ptr      (ptr_q),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        bank_d     = bank_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        we_d       = we_q;
        ba_d       = ba_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dm_d       = dm_q;
        prog_rdy_d = 1'b0;
        ack_d      = 4'b0;
        dst_d      = 4'b0;
        rdy_d      = 4'b0;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (PROG_WE) begin
                    state_d = ST_PROG_CMD;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    ba_d    = PROG_BA;
                    addr_d  = PROG_ADDR;
                    din_d   = PROG_DATA;
                    dm_d    = PROG_MASK;
                end else if (gnt_valid) begin
                    ptr_d  = rr_next(gnt_idx);
                    bank_d = gnt_idx;
                    cs_d   = 1'b1;
                    ba_d   = gnt_idx;
                    addr_d = ba_addr[gnt_idx];
                    if (gnt_idx == BANK_CPU && BA_WR) begin
                        state_d = ST_WR_CMD;
                        we_d    = 1'b1;
                        din_d   = BA0_DIN;
                        dm_d    = BA0_DIN_M;
                    end else begin
                        state_d = ST_RD_CMD;
                        we_d    = 1'b0;
                    end
                end
            end
            ST_PROG_CMD: begin
                if (mem_gnt) begin
                    cs_d       = 1'b0;
                    prog_rdy_d = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_WR_CMD: begin
                if (mem_gnt) begin
                    cs_d          = 1'b0;
                    ack_d[BANK_CPU] = 1'b1;
                    rdy_d[BANK_CPU] = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (mem_gnt) begin
                    cs_d          = 1'b0;
                    ack_d[bank_q] = 1'b1;
                    state_d       = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (mem_dvalid) begin
                    rdata_d = mem_dout;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        dst_d[bank_q] = 1'b1;
                    end
                    if (cnt_q == CW'(BURST - 1)) begin
                        rdy_d[bank_q] = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            bank_q     <= 2'd0;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            ba_q       <= 2'd0;
            addr_q     <= '0;
            din_q      <= 16'h0;
            dm_q       <= 2'd0;
            prog_rdy_q <= 1'b0;
            ack_q      <= 4'b0;
            dst_q      <= 4'b0;
            rdy_q      <= 4'b0;
            rdata_q    <= 16'h0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dm_q       <= dm_d;
            prog_rdy_q <= prog_rdy_d;
            ack_q      <= ack_d;
            dst_q      <= dst_d;
            rdy_q      <= rdy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign PROG_RDY  = prog_rdy_q;
    assign BA_ACK    = ack_q;
    assign BA_DST    = dst_q;
    assign BA_RDY    = rdy_q;
    assign DATA_READ = rdata_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_ba    = ba_q;
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign mem_dm    = dm_q;

endmodule

// File: tb/tb_snowbro2_sdram_resp.sv
// Scoreboard bench for snowbro2_sdram_resp with a zero-wait memory model.
// Expected reads/writes are queued at stimulus time and retired by a monitor.
module tb_snowbro2_sdram_resp;

    localparam int AW    = 22;
    localparam int BURST = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [AW-1:0] PROG_ADDR = '0;
    logic [15:0]   PROG_DATA = '0;
    logic [1:0]    PROG_MASK = '0;
    logic [1:0]    PROG_BA = '0;
    logic          PROG_WE = 1'b0;
    logic          PROG_RDY;
    logic [AW-1:0] BA0_ADDR = '0;
    logic [AW-1:0] BA1_ADDR = '0;
    logic [AW-1:0] BA2_ADDR = '0;
    logic [AW-1:0] BA3_ADDR = '0;
    logic [3:0]    BA_RD = '0;
    logic          BA_WR = 1'b0;
    logic [15:0]   BA0_DIN = '0;
    logic [1:0]    BA0_DIN_M = '0;
    logic [3:0]    BA_ACK;
    logic [3:0]    BA_DST;
    logic [3:0]    BA_RDY;
    logic [15:0]   DATA_READ;
    logic          mem_cs;
    logic          mem_we;
    logic [1:0]    mem_ba;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_dm;
    logic          mem_gnt;
    logic          mem_dvalid;
    logic [15:0]   mem_dout;

    logic gnt_en = 1'b1;
    logic mdl_en = 1'b1;
    logic [AW-1:0] ma;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    bank;
        logic [AW-1:0] addr;
    } rd_t;

    typedef struct {
        logic [1:0]    ba;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    dm;
    } wr_t;

    rd_t rd_exp[$];
    wr_t wr_exp[$];
    int  ack_log[$];
    int  prog_rdy_cnt = 0;
    int  wr_done_cnt = 0;

    always #5 CLK = ~CLK;

    assign mem_gnt = mem_cs & gnt_en;

    snowbro2_sdram_resp #(.AW(AW), .BURST(BURST)) dut (
        .CLK(CLK), .RESET(RESET),
        .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .PROG_MASK(PROG_MASK), .PROG_BA(PROG_BA),
        .PROG_WE(PROG_WE), .PROG_RDY(PROG_RDY),
        .BA0_ADDR(BA0_ADDR), .BA1_ADDR(BA1_ADDR),
        .BA2_ADDR(BA2_ADDR), .BA3_ADDR(BA3_ADDR),
        .BA_RD(BA_RD), .BA_WR(BA_WR),
        .BA0_DIN(BA0_DIN), .BA0_DIN_M(BA0_DIN_M),
        .BA_ACK(BA_ACK), .BA_DST(BA_DST), .BA_RDY(BA_RDY),
        .DATA_READ(DATA_READ),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_ba(mem_ba),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dm(mem_dm),
        .mem_gnt(mem_gnt), .mem_dvalid(mem_dvalid), .mem_dout(mem_dout)
    );

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a, input int i);
        if (a == 22'h12345) return (i == 0) ? 16'hAAAA : 16'h5555;
        return a[15:0] + 16'(i + 1);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory model: a granted read returns BURST words on consecutive cycles.
    initial begin
        mem_dvalid = 1'b0;
        mem_dout   = 16'h0;
        forever begin
            @(negedge CLK);
            if (mdl_en && !RESET && mem_cs && mem_gnt && !mem_we) begin
                ma = mem_addr;
                tick();
                for (int i = 0; i < BURST; i++) begin
                    mem_dvalid = 1'b1;
                    mem_dout   = mem_word(ma, i);
                    tick();
                end
                mem_dvalid = 1'b0;
            end
        end
    end

    // Monitor: retires scoreboard entries as commands and strobes appear.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                for (int b = 0; b < 4; b++)
                    if (BA_ACK[b]) ack_log.push_back(b);
                if (PROG_RDY) prog_rdy_cnt++;
                if (BA_ACK == 4'b0001 && BA_RDY == 4'b0001) begin
                    wr_done_cnt++;
                    checks++;
                    if (BA_DST !== 4'b0) begin
                        errors++;
                        $display("FAIL wr_dst: got %b want 0000", BA_DST);
                    end
                end else begin
                    if (BA_DST != 4'b0) begin
                        checks++;
                        if (rd_exp.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_dst: got %b want 0000", BA_DST);
                        end else if (BA_DST !== (4'b1 << rd_exp[0].bank) ||
                                     DATA_READ !== mem_word(rd_exp[0].addr, 0)) begin
                            errors++;
                            $display("FAIL dst_word: got %b/%h want %b/%h", BA_DST, DATA_READ,
                                     4'b1 << rd_exp[0].bank, mem_word(rd_exp[0].addr, 0));
                        end
                    end
                    if (BA_RDY != 4'b0) begin
                        checks++;
                        if (rd_exp.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_rdy: got %b want 0000", BA_RDY);
                        end else begin
                            if (BA_RDY !== (4'b1 << rd_exp[0].bank) ||
                                DATA_READ !== mem_word(rd_exp[0].addr, BURST - 1)) begin
                                errors++;
                                $display("FAIL rdy_word: got %b/%h want %b/%h", BA_RDY,
                                         DATA_READ, 4'b1 << rd_exp[0].bank,
                                         mem_word(rd_exp[0].addr, BURST - 1));
                            end
                            void'(rd_exp.pop_front());
                        end
                    end
                end
                if (mem_cs && mem_gnt) begin
                    checks++;
                    if (mem_we) begin
                        if (wr_exp.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: got addr %h want none", mem_addr);
                        end else begin
                            if (mem_ba !== wr_exp[0].ba || mem_addr !== wr_exp[0].addr ||
                                mem_din !== wr_exp[0].din || mem_dm !== wr_exp[0].dm) begin
                                errors++;
                                $display("FAIL write_cmd: got %0d/%h/%h/%b want %0d/%h/%h/%b",
                                         mem_ba, mem_addr, mem_din, mem_dm, wr_exp[0].ba,
                                         wr_exp[0].addr, wr_exp[0].din, wr_exp[0].dm);
                            end
                            void'(wr_exp.pop_front());
                        end
                    end else begin
                        if (rd_exp.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_read: got addr %h want none", mem_addr);
                        end else if (mem_ba !== rd_exp[0].bank || mem_addr !== rd_exp[0].addr) begin
                            errors++;
                            $display("FAIL read_cmd_order: got %0d/%h want %0d/%h", mem_ba,
                                     mem_addr, rd_exp[0].bank, rd_exp[0].addr);
                        end
                    end
                end
            end
        end
    end

    task automatic run_reads(input int budget);
        int n = 0;
        while ((rd_exp.size() != 0 || wr_exp.size() != 0 || BA_RD != 4'b0) && n < budget) begin
            tick();
            BA_RD = BA_RD & ~BA_ACK;
            n++;
        end
        checks++;
        if (rd_exp.size() != 0 || wr_exp.size() != 0 || BA_RD != 4'b0) begin
            errors++;
            $display("FAIL run_timeout: got %0d rd/%0d wr pending want 0", rd_exp.size(),
                     wr_exp.size());
        end
    endtask

    task automatic check_order(input string name, input int exp_ord[$]);
        checks++;
        if (ack_log.size() != exp_ord.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d acks want %0d", name, ack_log.size(), exp_ord.size());
        end else begin
            foreach (exp_ord[i]) begin
                checks++;
                if (ack_log[i] != exp_ord[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got bank %0d want %0d", name, i, ack_log[i], exp_ord[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        BA_RD = 4'b0; BA_WR = 1'b0; PROG_WE = 1'b0;
        RESET = 1'b1;
        tick(); tick();
        checks++;
        if ({PROG_RDY, BA_ACK, BA_DST, BA_RDY, DATA_READ} !== 29'h0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0", {PROG_RDY, BA_ACK, BA_DST, BA_RDY, DATA_READ});
        end
        checks++;
        if ({mem_cs, mem_we, mem_ba, mem_addr, mem_din, mem_dm} !== 44'h0) begin
            errors++;
            $display("FAIL reset_cmd: got %h want 0", {mem_cs, mem_we, mem_ba, mem_addr, mem_din, mem_dm});
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL idle_cs: got %b want 0", mem_cs);
        end
    endtask

    task automatic test_read_single();
        ack_log.delete();
        BA1_ADDR = 22'h12345;
        rd_exp.push_back('{2'd1, 22'h12345});
        BA_RD = 4'b0010;
        tick();
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_ba !== 2'd1 || mem_addr !== 22'h12345) begin
            errors++;
            $display("FAIL read_cmd: got cs%b we%b ba%0d %h want 1 0 1 12345", mem_cs, mem_we, mem_ba, mem_addr);
        end
        tick();
        checks++;
        if (BA_ACK !== 4'b0010) begin
            errors++;
            $display("FAIL read_ack: got %b want 0010", BA_ACK);
        end
        BA_RD = 4'b0;
        tick();
        checks++;
        if (BA_DST !== 4'b0010 || DATA_READ !== 16'hAAAA || BA_RDY !== 4'b0) begin
            errors++;
            $display("FAIL read_dst: got %b %h rdy %b want 0010 aaaa 0000", BA_DST, DATA_READ, BA_RDY);
        end
        tick();
        checks++;
        if (BA_RDY !== 4'b0010 || DATA_READ !== 16'h5555 || BA_DST !== 4'b0) begin
            errors++;
            $display("FAIL read_rdy: got %b %h dst %b want 0010 5555 0000", BA_RDY, DATA_READ, BA_DST);
        end
        run_reads(50);
        check_order("read_single", '{1});
    endtask

    task automatic test_prog();
        logic [1:0] masks[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        prog_rdy_cnt = 0;
        for (int i = 0; i < 4; i++)
            wr_exp.push_back('{2'd2, 22'h3F000 + 22'(i), 16'h1100 + 16'(i), masks[i]});
        PROG_BA = 2'd2;
        PROG_ADDR = 22'h3F000; PROG_DATA = 16'h1100; PROG_MASK = masks[0];
        PROG_WE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                checks++;
                if (mem_cs !== 1'b0) begin
                    errors++;
                    $display("FAIL prog_hold[%0d]: got cs %b want 0", i, mem_cs);
                end
            end
            tick();
            checks++;
            if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_dm !== masks[i]) begin
                errors++;
                $display("FAIL prog_cmd[%0d]: got cs%b we%b dm%b want 1 1 %b", i, mem_cs, mem_we, mem_dm, masks[i]);
            end
            tick();
            checks++;
            if (PROG_RDY !== 1'b1) begin
                errors++;
                $display("FAIL prog_rdy[%0d]: got %b want 1", i, PROG_RDY);
            end
            if (i < 3) begin
                PROG_ADDR = 22'h3F000 + 22'(i + 1);
                PROG_DATA = 16'h1100 + 16'(i + 1);
                PROG_MASK = masks[i + 1];
            end else begin
                PROG_WE = 1'b0;
            end
        end
        tick(); tick(); tick();
        checks++;
        if (prog_rdy_cnt != 4 || wr_exp.size() != 0 || mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL prog_total: got %0d rdy %0d pending cs%b want 4 0 0", prog_rdy_cnt, wr_exp.size(), mem_cs);
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        ack_log.delete();
        BA0_ADDR = 22'h200010; BA1_ADDR = 22'h201020;
        BA2_ADDR = 22'h202030; BA3_ADDR = 22'h203040;
        rd_exp.push_back('{2'd0, 22'h200010});
        rd_exp.push_back('{2'd1, 22'h201020});
        rd_exp.push_back('{2'd2, 22'h202030});
        rd_exp.push_back('{2'd3, 22'h203040});
        BA_RD = 4'b1111;
        run_reads(200);
        check_order("rr_all", '{0, 1, 2, 3});
        ack_log.delete();
        rd_exp.push_back('{2'd0, 22'h200010});
        rd_exp.push_back('{2'd3, 22'h203040});
        BA_RD = 4'b1001;
        run_reads(200);
        check_order("rr_03", '{0, 3});
    endtask

    task automatic test_prog_vs_read();
        ack_log.delete();
        prog_rdy_cnt = 0;
        BA0_ADDR = 22'h000456;
        PROG_BA = 2'd1; PROG_ADDR = 22'h00ABC; PROG_DATA = 16'h1234; PROG_MASK = 2'b00;
        wr_exp.push_back('{2'd1, 22'h00ABC, 16'h1234, 2'b00});
        rd_exp.push_back('{2'd0, 22'h000456});
        PROG_WE = 1'b1;
        BA_RD = 4'b0001;
        tick();
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL prog_first: got cs%b we%b want 1 1", mem_cs, mem_we);
        end
        tick();
        checks++;
        if (PROG_RDY !== 1'b1 || ack_log.size() != 0 || BA_ACK !== 4'b0) begin
            errors++;
            $display("FAIL prog_before_ack: got rdy%b ack%b want 1 0000", PROG_RDY, BA_ACK);
        end
        PROG_WE = 1'b0;
        run_reads(100);
        check_order("prog_then_b0", '{0});
    endtask

    task automatic test_ba_write();
        ack_log.delete();
        wr_done_cnt = 0;
        BA0_ADDR = 22'h000100; BA0_DIN = 16'hBEEF; BA0_DIN_M = 2'b00;
        wr_exp.push_back('{2'd0, 22'h000100, 16'hBEEF, 2'b00});
        BA_WR = 1'b1;
        tick();
        checks++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_ba !== 2'd0) begin
            errors++;
            $display("FAIL bawr_cmd: got cs%b we%b ba%0d want 1 1 0", mem_cs, mem_we, mem_ba);
        end
        tick();
        checks++;
        if (BA_ACK !== 4'b0001 || BA_RDY !== 4'b0001 || BA_DST !== 4'b0) begin
            errors++;
            $display("FAIL bawr_strobe: got ack%b rdy%b dst%b want 0001 0001 0000", BA_ACK, BA_RDY, BA_DST);
        end
        BA_WR = 1'b0;
        tick(); tick();
        checks++;
        if (wr_done_cnt != 1 || wr_exp.size() != 0 || mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL bawr_single: got %0d done %0d pending want 1 0", wr_done_cnt, wr_exp.size());
        end
    endtask

    task automatic test_reset_mid();
        mdl_en = 1'b0;
        BA2_ADDR = 22'h000777;
        rd_exp.push_back('{2'd2, 22'h000777});
        BA_RD = 4'b0100;
        tick(); tick();
        checks++;
        if (BA_ACK !== 4'b0100) begin
            errors++;
            $display("FAIL mid_ack: got %b want 0100", BA_ACK);
        end
        BA_RD = 4'b0;
        mem_dvalid = 1'b1;
        mem_dout = mem_word(22'h000777, 0);
        tick();
        checks++;
        if (BA_DST !== 4'b0100 || DATA_READ !== mem_word(22'h000777, 0)) begin
            errors++;
            $display("FAIL mid_dst: got %b %h want 0100 %h", BA_DST, DATA_READ, mem_word(22'h000777, 0));
        end
        RESET = 1'b1;
        mem_dvalid = 1'b0;
        tick();
        checks++;
        if ({PROG_RDY, BA_ACK, BA_DST, BA_RDY, DATA_READ, mem_cs, mem_we, mem_ba,
             mem_addr, mem_din, mem_dm} !== 73'h0) begin
            errors++;
            $display("FAIL mid_reset_out: got rdy%b dst%b data %h cs%b want all 0", BA_RDY, BA_DST, DATA_READ, mem_cs);
        end
        rd_exp.delete();
        RESET = 1'b0;
        mem_dvalid = 1'b1;
        mem_dout = 16'h2222;
        tick();
        mem_dvalid = 1'b0;
        tick();
        checks++;
        if (BA_DST !== 4'b0 || BA_RDY !== 4'b0 || DATA_READ !== 16'h0) begin
            errors++;
            $display("FAIL late_dvalid: got dst%b rdy%b %h want 0000 0000 0000", BA_DST, BA_RDY, DATA_READ);
        end
        mdl_en = 1'b1;
        ack_log.delete();
        BA1_ADDR = 22'h000E10; BA3_ADDR = 22'h000F00;
        rd_exp.push_back('{2'd1, 22'h000E10});
        rd_exp.push_back('{2'd3, 22'h000F00});
        BA_RD = 4'b1010;
        run_reads(100);
        check_order("after_reset", '{1, 3});
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_prog();
        test_round_robin();
        test_prog_vs_read();
        test_ba_write();
        test_reset_mid();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
